mu_dma_queue: RTL and testbench
===============================

Name: mu_dma_queue

Overview:
- Parametrised multi-channel DMA command queue for the MU, replacing the single-shot dma_wr/dma_rd/b2b request style.
- CU-side commands are buffered in a per-channel FIFO. Each entry is issued as a request pulse to its DMA engine, and completion is tracked through the engine's idle handshake.
- Provides per-channel completion interrupts, an acknowledge timeout with error flag, and a synchronous soft flush.

Parameters:
- CH_NUM, 2, number of DMA channels (1..8)
- DEPTH, 4, FIFO entries per channel (power of two, >=2)
- AW, 32, width of the addr/len/num/inc/resp_addr fields
- ACK_TO, 64, cycles allowed for idle to drop after a request
- CH_W, derived, max(1, clog2(CH_NUM))
- CNT_W, derived, clog2(DEPTH)+1

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous soft clear (cfg_mu_clear)
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command accepted when vld&rdy
- cmd_ch  in  CH_W  target channel
- cmd_addr  in  AW  base address
- cmd_len  in  AW  line length
- cmd_num  in  AW  line count
- cmd_inc  in  AW  line stride
- cmd_resp_addr  in  AW  response address
- dma_req  out  CH_NUM  per-channel request pulse
- dma_addr  out  CH_NUM*AW  flattened, channel i at [i*AW +: AW]
- dma_len  out  CH_NUM*AW  flattened
- dma_num  out  CH_NUM*AW  flattened
- dma_inc  out  CH_NUM*AW  flattened
- dma_resp_addr  out  CH_NUM*AW  flattened
- dma_idle  in  CH_NUM  engine idle
- irq_en  in  CH_NUM  interrupt enable
- irq_clr  in  CH_NUM  write-1-clear of pending bits
- irq_pend  out  CH_NUM  sticky done pending
- err_pend  out  CH_NUM  sticky ack-timeout
- interrupt  out  1  |(irq_pend & irq_en) | (|err_pend)
- q_cnt  out  CH_NUM*CNT_W  per-channel FIFO occupancy
- busy  out  1  any FIFO non-empty or any FSM not IDLE

Behaviour:
- Reset values:
  - All outputs 0, except cmd_rdy, which is 1.
  - FIFOs empty; all FSMs in IDLE.
- Command acceptance:
  - cmd_rdy = !flush & (FIFO[cmd_ch] not full).
  - cmd_rdy is combinational on cmd_ch.
  - cmd_ch >= CH_NUM: cmd_rdy=1, the command is dropped, and err_pend[0] is set.
- FIFO: push on vld&rdy. q_cnt updates the next cycle. Simultaneous push and pop on the same channel leaves the count unchanged. Pointers wrap modulo DEPTH.
- Per-channel FSM:
  - IDLE: if FIFO non-empty and dma_idle[i]=1, latch the head entry into the dma_* output registers and go to REQ. dma_* outputs hold their value until the next issue.
  - REQ: dma_req[i]=1 for exactly one cycle. Go to ACK and clear the timeout counter.
  - ACK: wait for dma_idle[i]=0.
    - On seeing 0, go to RUN.
    - If the counter reaches ACK_TO-1, set err_pend[i], pop the entry, and go to IDLE.
  - RUN: wait for dma_idle[i]=1. On seeing 1, pop the entry, set irq_pend[i], and go to IDLE.
- Issue latency: a command pushed into an empty FIFO on an idle channel gives dma_req high 2 cycles after the accept edge (one cycle to register, one in IDLE→REQ).
- Back-to-back issue: the minimum gap between dma_req pulses on one channel is 3 cycles.
- Channels are fully independent; all may request in the same cycle.
- irq_pend/err_pend:
  - Set and irq_clr in the same cycle: set wins.
  - irq_clr[i] clears both irq_pend[i] and err_pend[i].
- interrupt is registered, one cycle after the pend change.
- flush (priority over everything else, takes effect at the next edge):
  - FIFOs emptied, FSMs to IDLE, pend bits cleared, dma_req forced 0.
  - dma_* data registers retained.
  - An in-flight engine operation is not aborted; its idle edge is ignored.
- Async reset mid-operation returns every state element to its reset value immediately.

Test Plan:
- Single command:
  - Stimulus: accept ch0 addr=0x1000 len=0x40 num=4 inc=0x100, dma_idle=1; engine drops idle 2 cycles after req and raises it 10 cycles later.
  - Required: dma_req[0] pulses exactly once, 2 cycles after accept, with dma_addr[0]=0x1000. After idle rises: irq_pend[0]=1 and q_cnt[0]=0. With irq_en[0]=1, interrupt=1 the next cycle.
- Full/backpressure:
  - Stimulus: push 5 commands to ch1 with dma_idle[1]=0 held (DEPTH=4).
  - Required: 4 accepted, q_cnt[1]=4, cmd_rdy=0 on the 5th while ch0 pushes are still accepted. Releasing idle drains the FIFO in order (addr 0,1,2,3 tags).
- Ack timeout:
  - Stimulus: ch0 req with dma_idle held at 1.
  - Required: err_pend[0]=1 exactly ACK_TO cycles after ACK entry, entry popped, interrupt=1 even with irq_en=0.
- Parallel channels:
  - Stimulus: both channels loaded in the same cycle.
  - Required: dma_req=2'b11 in the same cycle; independent completion sets irq_pend bits separately. irq_clr=2'b01 coinciding with ch0 done leaves irq_pend[0]=1.
- Flush:
  - Stimulus: flush asserted during RUN with q_cnt=3.
  - Required: next cycle q_cnt=0, busy=0, irq_pend=0, cmd_rdy=0 while flush is high. A later idle rise produces no irq.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low during REQ.
  - Required: dma_req drops asynchronously; all outputs at reset values; cmd_rdy=1 after release.

Source files
------------

// File: rtl/mu_dma_queue_if.sv
// Command and DMA-engine bundle for the MU DMA queue.
// The CU drives it as master and the queue is the slave.
interface mu_dma_queue_if #(
  parameter int CH_NUM = 2,
  parameter int AW     = 32
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic [CH_W-1:0]      cmd_ch;
  logic [AW-1:0]        cmd_addr;
  logic [AW-1:0]        cmd_len;
  logic [AW-1:0]        cmd_num;
  logic [AW-1:0]        cmd_inc;
  logic [AW-1:0]        cmd_resp_addr;

  logic [CH_NUM-1:0]    dma_req;
  logic [CH_NUM*AW-1:0] dma_addr;
  logic [CH_NUM*AW-1:0] dma_len;
  logic [CH_NUM*AW-1:0] dma_num;
  logic [CH_NUM*AW-1:0] dma_inc;
  logic [CH_NUM*AW-1:0] dma_resp_addr;
  logic [CH_NUM-1:0]    dma_idle;

  modport master (
    output cmd_vld, cmd_ch, cmd_addr, cmd_len, cmd_num, cmd_inc, cmd_resp_addr, dma_idle,
    input  cmd_rdy, dma_req, dma_addr, dma_len, dma_num, dma_inc, dma_resp_addr
  );

  modport slave (
    input  cmd_vld, cmd_ch, cmd_addr, cmd_len, cmd_num, cmd_inc, cmd_resp_addr, dma_idle,
    output cmd_rdy, dma_req, dma_addr, dma_len, dma_num, dma_inc, dma_resp_addr
  );
endinterface

// File: rtl/mu_dma_queue.sv
// Multi-channel DMA command queue: per-channel FIFO feeding a
// request/ack/run handshake FSM with done and ack-timeout interrupts.
module mu_dma_queue #(
  parameter int  CH_NUM = 2,
  parameter int  DEPTH  = 4,
  parameter int  AW     = 32,
  parameter int  ACK_TO = 64,
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  mu_dma_queue_if.slave           bus,
  input  logic [CH_NUM-1:0]       irq_en,
  input  logic [CH_NUM-1:0]       irq_clr,
  output logic [CH_NUM-1:0]       irq_pend,
  output logic [CH_NUM-1:0]       err_pend,
  output logic                    interrupt,
  output logic [CH_NUM*CNT_W-1:0] q_cnt,
  output logic                    busy
);
  localparam int PW   = $clog2(DEPTH);
  localparam int TO_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam int EW   = 5 * AW;

  typedef enum logic [1:0] {IDLE, REQ, ACK, RUN} state_t;

  logic [CH_NUM-1:0] full;
  logic [CH_NUM-1:0] push;
  logic [CH_NUM-1:0] pop;
  logic [CH_NUM-1:0] active;
  logic              ch_bad;
  logic              drop;

  // Commands to a non-existent channel are swallowed and flagged on channel 0.
  assign ch_bad      = (32'(bus.cmd_ch) >= CH_NUM);
  assign bus.cmd_rdy = !flush && (ch_bad || !full[bus.cmd_ch]);
  assign drop        = bus.cmd_vld && bus.cmd_rdy && ch_bad;
  assign busy        = |active;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;
    logic [EW-1:0]    data_r;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             req_r;
    logic             irq_r;
    logic             err_r;
    logic             timeout;
    logic             done;
    logic             err_set;
    state_t           state;

    assign head     = mem[rd_ptr];
    assign full[i]  = (cnt == CNT_W'(DEPTH));
    assign push[i]  = bus.cmd_vld && bus.cmd_rdy && !ch_bad && (bus.cmd_ch == CH_W'(i));
    assign timeout  = (state == ACK) && bus.dma_idle[i] && (to_cnt == TO_W'(ACK_TO - 1));
    assign done     = (state == RUN) && bus.dma_idle[i];
    assign pop[i]   = timeout || done;
    assign err_set  = timeout || ((i == 0) && drop);
    assign active[i] = (state != IDLE) || (cnt != '0);

    assign q_cnt[i*CNT_W +: CNT_W]   = cnt;
    assign bus.dma_req[i]            = req_r;
    assign bus.dma_addr[i*AW +: AW]      = data_r[0*AW +: AW];
    assign bus.dma_len[i*AW +: AW]       = data_r[1*AW +: AW];
    assign bus.dma_num[i*AW +: AW]       = data_r[2*AW +: AW];
    assign bus.dma_inc[i*AW +: AW]       = data_r[3*AW +: AW];
    assign bus.dma_resp_addr[i*AW +: AW] = data_r[4*AW +: AW];
    assign irq_pend[i] = irq_r;
    assign err_pend[i] = err_r;

    always_ff @(posedge clk) begin
      if (push[i])
        mem[wr_ptr] <= {bus.cmd_resp_addr, bus.cmd_inc, bus.cmd_num, bus.cmd_len, bus.cmd_addr};
    end

    // The entry stays counted in the FIFO until its engine op completes or times out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        to_cnt <= '0;
        req_r  <= 1'b0;
        irq_r  <= 1'b0;
        err_r  <= 1'b0;
        data_r <= '0;
      end else if (flush) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        to_cnt <= '0;
        req_r  <= 1'b0;
        irq_r  <= 1'b0;
        err_r  <= 1'b0;
      end else begin
        req_r <= 1'b0;
        if (push[i])
          wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])
          rd_ptr <= rd_ptr + 1'b1;
        cnt   <= cnt + CNT_W'(push[i]) - CNT_W'(pop[i]);
        irq_r <= done || (irq_r && !irq_clr[i]);
        err_r <= err_set || (err_r && !irq_clr[i]);
        case (state)
          IDLE: begin
            if ((cnt != '0) && bus.dma_idle[i]) begin
              data_r <= head;
              req_r  <= 1'b1;
              state  <= REQ;
            end
          end
          REQ: begin
            to_cnt <= '0;
            state  <= ACK;
          end
          ACK: begin
            if (!bus.dma_idle[i])
              state <= RUN;
            else if (timeout)
              state <= IDLE;
            else
              to_cnt <= to_cnt + 1'b1;
          end
          RUN: begin
            if (bus.dma_idle[i])
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      interrupt <= 1'b0;
    else if (flush)
      interrupt <= 1'b0;
    else
      interrupt <= (|(irq_pend & irq_en)) || (|err_pend);
  end
endmodule

// File: tb/tb_mu_dma_queue.sv
// Directed self-checking bench for mu_dma_queue (2 channels, depth 4).
// Each step drives inputs just after a rising edge and checks registered outputs there.
module tb_mu_dma_queue;
  localparam int CH_NUM = 2;
  localparam int DEPTH  = 4;
  localparam int AW     = 32;
  localparam int ACK_TO = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic [CH_NUM-1:0]       irq_en;
  logic [CH_NUM-1:0]       irq_clr;
  logic [CH_NUM-1:0]       irq_pend;
  logic [CH_NUM-1:0]       err_pend;
  logic                    interrupt;
  logic [CH_NUM*CNT_W-1:0] q_cnt;
  logic                    busy;

  int errors   = 0;
  int checks   = 0;
  int req_cnt0 = 0;
  int snap     = 0;
  bit seen;

  mu_dma_queue_if #(.CH_NUM(CH_NUM), .AW(AW)) bus ();

  mu_dma_queue #(.CH_NUM(CH_NUM), .DEPTH(DEPTH), .AW(AW), .ACK_TO(ACK_TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .irq_en    (irq_en),
    .irq_clr   (irq_clr),
    .irq_pend  (irq_pend),
    .err_pend  (err_pend),
    .interrupt (interrupt),
    .q_cnt     (q_cnt),
    .busy      (busy)
  );

  logic [AW-1:0]    addr0, addr1;
  logic [CNT_W-1:0] q0, q1;
  assign addr0 = bus.dma_addr[0*AW +: AW];
  assign addr1 = bus.dma_addr[1*AW +: AW];
  assign q0    = q_cnt[0*CNT_W +: CNT_W];
  assign q1    = q_cnt[1*CNT_W +: CNT_W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && bus.dma_req[0]) req_cnt0++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic ch, input logic [AW-1:0] addr);
    bus.cmd_vld       = vld;
    bus.cmd_ch        = ch;
    bus.cmd_addr      = addr;
    bus.cmd_len       = addr + 32'h40;
    bus.cmd_num       = 32'd4;
    bus.cmd_inc       = 32'h100;
    bus.cmd_resp_addr = addr + 32'h2000;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_req(input int ch, output bit found);
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      tick();
      if (bus.dma_req[ch]) found = 1'b1;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    irq_en       = '0;
    irq_clr      = '0;
    bus.dma_idle = 2'b11;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("rst_req",  bus.dma_req, 2'b00);
    checkOutput("rst_rdy",  bus.cmd_rdy, 1'b1);
    checkOutput("rst_irq",  irq_pend, 2'b00);
    checkOutput("rst_err",  err_pend, 2'b00);
    checkOutput("rst_int",  interrupt, 1'b0);
    checkOutput("rst_qcnt", q_cnt, 6'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_addr", addr0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] single command");
    irq_en = 2'b01;
    applyStimulus(1'b1, 1'b0, 32'h1000);
    #1;
    checkOutput("t1_rdy", bus.cmd_rdy, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_q_after_push", q0, 3'd1);
    checkOutput("t1_req_early", bus.dma_req, 2'b00);
    tick();
    checkOutput("t1_req", bus.dma_req, 2'b01);
    checkOutput("t1_addr", addr0, 32'h1000);
    checkOutput("t1_len", bus.dma_len[0*AW +: AW], 32'h1040);
    tick();
    checkOutput("t1_req_one_cycle", bus.dma_req, 2'b00);
    tick();
    bus.dma_idle[0] = 1'b0;
    repeat (10) tick();
    checkOutput("t1_irq_running", irq_pend, 2'b00);
    checkOutput("t1_busy_running", busy, 1'b1);
    checkOutput("t1_q_running", q0, 3'd1);
    bus.dma_idle[0] = 1'b1;
    tick();
    checkOutput("t1_irq_done", irq_pend, 2'b01);
    checkOutput("t1_q_done", q0, 3'd0);
    checkOutput("t1_int_lag", interrupt, 1'b0);
    checkOutput("t1_busy_done", busy, 1'b0);
    tick();
    checkOutput("t1_int", interrupt, 1'b1);
    checkOutput("t1_req_count", req_cnt0, 1);
    irq_clr = 2'b01;
    tick();
    irq_clr = 2'b00;
    checkOutput("t1_irq_clr", irq_pend, 2'b00);
    tick();
    checkOutput("t1_int_clr", interrupt, 1'b0);
    irq_en = 2'b00;

    $display("[TB] full and backpressure");
    bus.dma_idle = 2'b00;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 32'(k));
      #1;
      checkOutput("t2_rdy_fill", bus.cmd_rdy, 1'b1);
      tick();
    end
    checkOutput("t2_q1_full", q1, 3'd4);
    applyStimulus(1'b1, 1'b1, 32'h4);
    #1;
    checkOutput("t2_rdy_full", bus.cmd_rdy, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hC0DE);
    #1;
    checkOutput("t2_rdy_ch0", bus.cmd_rdy, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t2_q0", q0, 3'd1);
    checkOutput("t2_q1_still", q1, 3'd4);
    bus.dma_idle[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req(1, seen);
      checkOutput("t2_issue", seen, 1'b1);
      checkOutput("t2_order", addr1, 32'(k));
      bus.dma_idle[1] = 1'b0;
      tick();
      tick();
      bus.dma_idle[1] = 1'b1;
      tick();
    end
    checkOutput("t2_q1_drained", q1, 3'd0);
    checkOutput("t2_irq", irq_pend, 2'b10);
    checkOutput("t2_q0_held", q0, 3'd1);
    irq_clr = 2'b10;
    tick();
    irq_clr = 2'b00;
    checkOutput("t2_irq_clr", irq_pend, 2'b00);

    $display("[TB] ack timeout");
    bus.dma_idle[0] = 1'b1;
    tick();
    checkOutput("t3_req", bus.dma_req, 2'b01);
    checkOutput("t3_addr", addr0, 32'hC0DE);
    tick();
    repeat (ACK_TO - 1) tick();
    checkOutput("t3_err_early", err_pend, 2'b00);
    tick();
    checkOutput("t3_err", err_pend, 2'b01);
    checkOutput("t3_q_popped", q0, 3'd0);
    checkOutput("t3_busy", busy, 1'b0);
    checkOutput("t3_int_lag", interrupt, 1'b0);
    tick();
    checkOutput("t3_int", interrupt, 1'b1);
    checkOutput("t3_no_reissue", bus.dma_req, 2'b00);
    irq_clr = 2'b01;
    tick();
    irq_clr = 2'b00;
    checkOutput("t3_err_clr", err_pend, 2'b00);

    $display("[TB] parallel channels");
    bus.dma_idle = 2'b00;
    applyStimulus(1'b1, 1'b0, 32'hA0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'hB0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t4_qcnt", q_cnt, {3'd1, 3'd1});
    bus.dma_idle = 2'b11;
    tick();
    checkOutput("t4_req_both", bus.dma_req, 2'b11);
    checkOutput("t4_addr0", addr0, 32'hA0);
    checkOutput("t4_addr1", addr1, 32'hB0);
    bus.dma_idle = 2'b00;
    tick();
    tick();
    bus.dma_idle = 2'b10;
    tick();
    checkOutput("t4_irq_ch1", irq_pend, 2'b10);
    bus.dma_idle = 2'b11;
    irq_clr = 2'b01;
    tick();
    irq_clr = 2'b00;
    checkOutput("t4_set_wins", irq_pend, 2'b11);

    $display("[TB] flush");
    applyStimulus(1'b1, 1'b0, 32'h10);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h20);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h30);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    bus.dma_idle[0] = 1'b0;
    tick();
    checkOutput("t5_q_pre", q0, 3'd3);
    checkOutput("t5_busy_pre", busy, 1'b1);
    checkOutput("t5_irq_pre", irq_pend, 2'b11);
    flush = 1'b1;
    #1;
    checkOutput("t5_rdy_flush", bus.cmd_rdy, 1'b0);
    tick();
    checkOutput("t5_qcnt", q_cnt, 6'd0);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_irq", irq_pend, 2'b00);
    checkOutput("t5_req", bus.dma_req, 2'b00);
    checkOutput("t5_addr_kept", addr0, 32'h10);
    checkOutput("t5_rdy_still", bus.cmd_rdy, 1'b0);
    flush = 1'b0;
    snap = req_cnt0;
    bus.dma_idle[0] = 1'b1;
    repeat (3) tick();
    checkOutput("t5_no_irq", irq_pend, 2'b00);
    checkOutput("t5_no_int", interrupt, 1'b0);
    checkOutput("t5_no_req", req_cnt0, snap);
    checkOutput("t5_rdy_after", bus.cmd_rdy, 1'b1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b1, 32'hBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("t6_req", bus.dma_req, 2'b10);
    checkOutput("t6_addr", addr1, 32'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_req_async", bus.dma_req, 2'b00);
    checkOutput("t6_addr_rst", addr1, 32'h0);
    checkOutput("t6_qcnt", q_cnt, 6'd0);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_rdy_rst", bus.cmd_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("t6_rdy_after", bus.cmd_rdy, 1'b1);
    checkOutput("t6_req_after", bus.dma_req, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
